cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Instruction-sequencing control unit for the 8-bit accumulator CPU.
- Sits directly upstream of the accumulator and drives its 2-bit load enable (10 = load from data memory, 01 = load ALU result, 00 = hold).
- Also drives PC, IR, data memory strobes, address mux select and ALU opcode.
- Multi-cycle: every instruction takes a fixed 5-state walk, except HLT, which parks.

Parameters:
- OPW, 3, opcode width (instruction bits [7:5])
- OPERAND_SEL, 1'b1, addr_sel value that selects the IR operand field; the PC is selected by ~OPERAND_SEL

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- opcode  in  OPW  IR[7:5]; valid from the state after FETCH2
- ac_zero  in  1  accumulator == 8'h00, from the accumulator output
- ir_load  out  1  IR captures memory read data this edge
- pc_inc  out  1  PC <= PC+1 this edge
- pc_load  out  1  PC <= IR operand this edge
- addr_sel  out  1  memory address mux select: PC or operand
- mem_rd  out  1  data memory read strobe
- mem_wr  out  1  data memory write strobe (writes the accumulator value)
- ac_en  out  2  accumulator enable: 2'b10 file, 2'b01 alu, 2'b00 hold
- alu_op  out  OPW  opcode forwarded to the ALU
- halted  out  1  high while in HALT

Behaviour:
- Opcodes:
  - 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- Register usage:
  - Only the state register (one-hot or binary, implementer's choice) is sequential.
  - All outputs are Moore, decoded from state plus the registered opcode.
  - opcode is sampled into an internal register in DECODE and held through EXEC2.
  - alu_op = that registered opcode.
- Reset:
  - Async assert puts the FSM in FETCH1.
  - Every output decodes to 0 during reset, except addr_sel = ~OPERAND_SEL (PC).
  - Deassert is synchronous to clk on the next edge.
- States and per-state outputs (unlisted outputs are 0):
  - FETCH1: addr_sel=PC, mem_rd=1 -> FETCH2
  - FETCH2: addr_sel=PC, mem_rd=1, ir_load=1 -> DECODE
  - DECODE: pc_inc=1; opcode latched. HLT -> HALT, else -> EXEC1
  - EXEC1: addr_sel=operand. mem_rd=1 for ADD/AND/XOR/LDA. -> EXEC2
  - EXEC2 (addr_sel=operand):
    - ADD/AND/XOR: mem_rd=1, ac_en=01
    - LDA: mem_rd=1, ac_en=10
    - STO: mem_wr=1
    - JMP: pc_load=1
    - SKZ: pc_inc=1 if ac_zero, else nothing
    - Then -> FETCH1
  - HALT: halted=1, ac_en=00, no strobes. Stays in HALT until reset.
- Invariants:
  - ac_en is never 2'b11. ac_en=00 in every state except EXEC2.
  - pc_inc and pc_load are never high together. mem_rd and mem_wr are never high together.
- Latency:
  - 5 clocks per non-HLT instruction; SKZ is also 5 clocks.
  - SKZ with ac_zero=1 advances PC by 2 over the instruction (DECODE +1, EXEC2 +1).
- ac_zero is sampled in EXEC2 only. Changes to it at other times have no effect.
- Reset asserted mid-instruction (any state) aborts immediately:
  - No partial mem_wr or ac_en pulse survives past the reset edge.
  - Restart is at FETCH1.
- Unknown/X opcode must not occur. The 3-bit decode is full, so there is no default trap.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_HLT..OP_JMP)
  - AC_EN_HOLD=2'b00, AC_EN_ALU=2'b01, AC_EN_FILE=2'b10 (the accumulator uses the same constants)
  - state encoding constants
- No sub-module. This is a single FSM with registered opcode and an output decode block.

Test Plan:
- Reset then release, memory word 0 = 8'hA3 (LDA 3), mem[3]=8'h5C: ir_load is seen in cycle 2, pc_inc in cycle 3, ac_en=10 with mem_rd in cycle 5; accumulator = 8'h5C after cycle 5.
- ADD sequence, opcode 010: alu_op=3'b010 in EXEC1/EXEC2; ac_en=01 exactly one cycle (EXEC2); ac_en=00 in the other 4 cycles.
- SKZ with ac_zero=1: pc_inc pulses in DECODE and EXEC2 (PC advances +2). Repeat with ac_zero=0: a single pc_inc pulse.
- JMP 5'h1F (8'hFF): pc_load=1 in EXEC2, pc_inc not asserted in EXEC2; the next FETCH1 reads address 8'h1F.
- STO then HLT: mem_wr=1 for one cycle only; after HLT's DECODE, halted=1 indefinitely (check 20 cycles), all strobes 0, ac_en=00.
- Assert rst in EXEC1 of STO: mem_wr never pulses. After release, the FSM is in FETCH1 with addr_sel=PC and mem_rd=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU.
// Opcodes, accumulator enables and control FSM state encoding.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [1:0] AC_EN_HOLD = 2'b00;
  localparam logic [1:0] AC_EN_ALU  = 2'b01;
  localparam logic [1:0] AC_EN_FILE = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH1 = 3'd0,
    S_FETCH2 = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
  endfunction

  // Opcodes that need a data memory read of the operand
  function automatic logic reads_mem(input logic [2:0] op);
    return is_alu(op) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control bundle between the sequencer and the CPU datapath.
// master = control FSM, slave = datapath (PC, IR, AC, memory).
interface cpu_ctrl_fsm_if #(
  parameter int OPW = 3
);
  logic [OPW-1:0] opcode;
  logic           ac_zero;
  logic           ir_load;
  logic           pc_inc;
  logic           pc_load;
  logic           addr_sel;
  logic           mem_rd;
  logic           mem_wr;
  logic [1:0]     ac_en;
  logic [OPW-1:0] alu_op;
  logic           halted;

  modport master (
    input  opcode, ac_zero,
    output ir_load, pc_inc, pc_load, addr_sel,
    output mem_rd, mem_wr, ac_en, alu_op, halted
  );

  modport slave (
    output opcode, ac_zero,
    input  ir_load, pc_inc, pc_load, addr_sel,
    input  mem_rd, mem_wr, ac_en, alu_op, halted
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Instruction sequencer: fixed 5-state walk per instruction,
// HLT parks in HALT. Moore outputs from state + latched opcode.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int   OPW         = 3,
  parameter logic OPERAND_SEL = 1'b1
) (
  input logic          clk,
  input logic          rst,
  cpu_ctrl_fsm_if.master bus
);

  state_e         state;
  logic [OPW-1:0] op_q;
  logic [2:0]     op;
  logic [2:0]     op_in;

  assign op    = 3'(op_q);
  assign op_in = 3'(bus.opcode);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH1;
      op_q  <= '0;
    end else begin
      unique case (state)
        S_FETCH1: state <= S_FETCH2;
        S_FETCH2: state <= S_DECODE;
        S_DECODE: begin
          op_q  <= bus.opcode;
          state <= (op_in == OP_HLT) ? S_HALT : S_EXEC1;
        end
        S_EXEC1:  state <= S_EXEC2;
        S_EXEC2:  state <= S_FETCH1;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH1;
      endcase
    end
  end

  // Reset forces every strobe low so nothing leaks while rst is held
  always_comb begin
    bus.ir_load  = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.addr_sel = ~OPERAND_SEL;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.ac_en    = AC_EN_HOLD;
    bus.alu_op   = rst ? op_q : '0;
    bus.halted   = 1'b0;
    if (rst) begin
      unique case (state)
        S_FETCH1: bus.mem_rd = 1'b1;
        S_FETCH2: begin
          bus.mem_rd  = 1'b1;
          bus.ir_load = 1'b1;
        end
        S_DECODE: bus.pc_inc = 1'b1;
        S_EXEC1: begin
          bus.addr_sel = OPERAND_SEL;
          bus.mem_rd   = reads_mem(op);
        end
        S_EXEC2: begin
          bus.addr_sel = OPERAND_SEL;
          unique case (1'b1)
            is_alu(op): begin
              bus.mem_rd = 1'b1;
              bus.ac_en  = AC_EN_ALU;
            end
            (op == OP_LDA): begin
              bus.mem_rd = 1'b1;
              bus.ac_en  = AC_EN_FILE;
            end
            (op == OP_STO): bus.mem_wr  = 1'b1;
            (op == OP_JMP): bus.pc_load = 1'b1;
            (op == OP_SKZ): bus.pc_inc  = bus.ac_zero;
            default: ;
          endcase
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench: sequencer driving a small accumulator CPU
// model; expected per-cycle control vectors are queued and checked.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

  typedef struct {
    string      nm;
    logic [11:0] o;
    bit         chk_arch;
    logic [7:0] pc;
    logic [7:0] ac;
    bit         chk_mem;
    logic [7:0] ma;
    logic [7:0] mv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_ctrl_fsm_if #(.OPW(3)) bus ();

  cpu_ctrl_fsm #(.OPW(3), .OPERAND_SEL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] pc, ir, ac;
  logic [7:0] pc_rst = 8'h00;
  logic [7:0] addr, rdata;
  bit         loaded;

  assign addr        = bus.addr_sel ? {3'b000, ir[4:0]} : pc;
  assign rdata       = mem[addr];
  assign bus.opcode  = ir[7:5];
  assign bus.ac_zero = (ac == 8'h00);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= pc_rst;
      ir <= 8'h00;
      ac <= 8'h00;
      if (!loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h00] <= 8'hA3;
        mem[8'h01] <= 8'h48;
        mem[8'h02] <= 8'hE9;
        mem[8'h03] <= 8'h5C;
        mem[8'h08] <= 8'h11;
        mem[8'h09] <= 8'h20;
        mem[8'h0A] <= 8'h6C;
        mem[8'h0B] <= 8'h20;
        mem[8'h0D] <= 8'h98;
        mem[8'h0E] <= 8'hFF;
        mem[8'h17] <= 8'h77;
        mem[8'h18] <= 8'hA5;
        mem[8'h1F] <= 8'hD6;
        loaded <= 1'b1;
      end
    end else begin
      if (bus.ir_load) ir <= rdata;
      if (bus.pc_inc) pc <= pc + 8'd1;
      if (bus.pc_load) pc <= {3'b000, ir[4:0]};
      if (bus.mem_wr) mem[addr] <= ac;
      case (bus.ac_en)
        AC_EN_FILE: ac <= rdata;
        AC_EN_ALU: begin
          case (bus.alu_op)
            OP_ADD:  ac <= ac + rdata;
            OP_AND:  ac <= ac & rdata;
            OP_XOR:  ac <= ac ^ rdata;
            default: ac <= ac;
          endcase
        end
        default: ;
      endcase
    end
  end

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [2:0] last_op = OP_HLT;

  function automatic logic [11:0] mk(
    input logic il, pi, pl, as, rd, wr,
    input logic [1:0] ae, input logic [2:0] op, input logic h);
    return {il, pi, pl, as, rd, wr, ae, op, h};
  endfunction

  task automatic push(input string nm, input logic [11:0] o,
                      input bit ca = 0, input logic [7:0] p = 0,
                      input logic [7:0] a = 0, input bit cm = 0,
                      input logic [7:0] ma = 0, input logic [7:0] mv = 0);
    exp_t e;
    e.nm = nm; e.o = o; e.chk_arch = ca; e.pc = p; e.ac = a;
    e.chk_mem = cm; e.ma = ma; e.mv = mv;
    q.push_back(e);
  endtask

  task automatic push_rst(input int n, input bit cm = 0,
                          input logic [7:0] ma = 0,
                          input logic [7:0] mv = 0);
    for (int i = 0; i < n; i++)
      push("reset", mk(0,0,0,0,0,0,2'b00,3'b000,0), 0, 0, 0,
           cm && (i == n - 1), ma, mv);
    last_op = OP_HLT;
  endtask

  // Expected 5-cycle walk; n truncates it, hn = HALT cycles for HLT
  task automatic push_instr(input logic [2:0] op, input bit acz,
                            input logic [7:0] p, input logic [7:0] a,
                            input int n = 5, input int hn = 20,
                            input bit cm = 0, input logic [7:0] ma = 0,
                            input logic [7:0] mv = 0);
    logic rd;
    logic [1:0] ae;
    rd = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    ae = (op == OP_LDA) ? 2'b10 : (rd ? 2'b01 : 2'b00);
    push("fetch1", mk(0,0,0,0,1,0,2'b00,last_op,0), 1, p, a, cm, ma, mv);
    if (n > 1) push("fetch2", mk(1,0,0,0,1,0,2'b00,last_op,0));
    if (n > 2) push("decode", mk(0,1,0,0,0,0,2'b00,last_op,0));
    if (op == OP_HLT) begin
      for (int i = 0; i < hn; i++)
        push("halt", mk(0,0,0,0,0,0,2'b00,OP_HLT,1));
      last_op = OP_HLT;
      return;
    end
    if (n > 3) push("exec1", mk(0,0,0,1,rd,0,2'b00,op,0));
    if (n > 4)
      push("exec2", mk(0, (op == OP_SKZ) && acz, op == OP_JMP, 1, rd,
                       op == OP_STO, ae, op, 0));
    last_op = op;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (q.size() > 0 && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      $display("FAIL drain: %0d entries still queued after %0d cycles",
               q.size(), max_cyc);
      $fatal(1, "scoreboard did not drain");
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e = q.pop_front();
      act = {bus.ir_load, bus.pc_inc, bus.pc_load, bus.addr_sel,
             bus.mem_rd, bus.mem_wr, bus.ac_en, bus.alu_op, bus.halted};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL %s ctrl: got %b expected %b (il pi pl as rd wr ae op h)",
                 e.nm, act, e.o);
      end
      if (e.chk_arch) begin
        checks++;
        if (pc !== e.pc) begin
          errors++;
          $display("FAIL %s pc: got %h expected %h", e.nm, pc, e.pc);
        end
        checks++;
        if (ac !== e.ac) begin
          errors++;
          $display("FAIL %s ac: got %h expected %h", e.nm, ac, e.ac);
        end
      end
      if (e.chk_mem) begin
        checks++;
        if (mem[e.ma] !== e.mv) begin
          errors++;
          $display("FAIL %s mem[%h]: got %h expected %h",
                   e.nm, e.ma, mem[e.ma], e.mv);
        end
      end
    end
  end

  initial begin
    push_rst(2);
    drain(10);
    @(posedge clk);
    #1 rst = 1'b1;
    push_instr(OP_LDA, 0, 8'h00, 8'h00);
    push_instr(OP_ADD, 0, 8'h01, 8'h5C);
    push_instr(OP_JMP, 0, 8'h02, 8'h6D);
    push_instr(OP_SKZ, 0, 8'h09, 8'h6D);
    push_instr(OP_AND, 0, 8'h0A, 8'h6D);
    push_instr(OP_SKZ, 1, 8'h0B, 8'h00);
    push_instr(OP_XOR, 0, 8'h0D, 8'h00);
    push_instr(OP_JMP, 0, 8'h0E, 8'hA5);
    push_instr(OP_STO, 0, 8'h1F, 8'hA5);
    push_instr(OP_HLT, 0, 8'h20, 8'hA5, 5, 20, 1, 8'h16, 8'hA5);
    drain(100);

    pc_rst = 8'h1F;
    rst = 1'b0;
    push_rst(2);
    drain(10);
    @(posedge clk);
    #1 rst = 1'b1;
    push_instr(OP_STO, 0, 8'h1F, 8'h00, 4);
    drain(10);
    rst = 1'b0;
    push_rst(2, 1, 8'h16, 8'hA5);
    drain(10);
    @(posedge clk);
    #1 rst = 1'b1;
    push_instr(OP_STO, 0, 8'h1F, 8'h00);
    push_instr(OP_HLT, 0, 8'h20, 8'h00, 5, 3, 1, 8'h16, 8'h00);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
